// File: rtl/big2_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : big2_game_ctrl
// Brief   : Big-2 turn sequencer driving the card datapath with a 4-phase
//           command/DONE handshake. BIG2_P1_AUTOPASS_EN adds a P1 idle auto-pass.
// Revision: 1.0
// ============================================================================
module big2_game_ctrl #(
  parameter int LOAD_CYCLES   = 2,
  parameter int DONE_TIMEOUT  = 16,
  parameter int P1_IDLE_LIMIT = 255
) (
  input  logic       clka,
  input  logic       RESTART_N,
  input  logic       START,
  input  logic       P1_PLAY,
  input  logic       P1_PASS,
  input  logic       DONE,
  input  logic       is_larger,
  input  logic       P2_PUT_CARD,
  input  logic [2:0] P1_OUT_NUM,
  input  logic [2:0] P2_OUT_NUM,
  output logic       LOAD,
  output logic       COMPARE_1,
  output logic       COMPARE_2,
  output logic       UPDATE_1,
  output logic       UPDATE_2,
  output logic       RESET_TOP,
  output logic [1:0] WINNER,
  output logic       P1_TURN,
  output logic       BAD_PLAY,
  output logic       ERR_FLAG,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LDECK = 4'd1,
    S_P1W   = 4'd2,
    S_P1L   = 4'd3,
    S_C1    = 4'd4,
    S_U1    = 4'd5,
    S_P2C   = 4'd6,
    S_U2    = 4'd7,
    S_RST   = 4'd8,
    S_DRAIN = 4'd9,
    S_WIN   = 4'd10,
    S_ERR   = 4'd15
  } state_t;

  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int TW = $clog2(DONE_TIMEOUT);
  localparam logic [LW-1:0] C_LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [TW-1:0] C_TMO_LAST  = TW'(DONE_TIMEOUT - 1);

  state_t        state, nstate;
  state_t        ret_state, nret;
  state_t        drain_next, ndrain;
  logic [LW-1:0] lcnt, nlcnt;
  logic [TW-1:0] tmo, ntmo;
  logic [1:0]    nwinner;
  logic          nbad;
  logic          handshake;
  logic          autopass;

`ifdef BIG2_P1_AUTOPASS_EN
  localparam int IW = $clog2(P1_IDLE_LIMIT + 1);
  logic [IW-1:0] idle_cnt;

  assign autopass = (idle_cnt == IW'(P1_IDLE_LIMIT - 1));

  // Held at zero outside P1W so every entry into P1W starts a fresh count.
  always_ff @(posedge clka or negedge RESTART_N) begin
    if (!RESTART_N)         idle_cnt <= '0;
    else if (state != S_P1W) idle_cnt <= '0;
    else if (!autopass)     idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign autopass = (P1_IDLE_LIMIT < 0);
`endif

  always_comb begin
    nstate    = state;
    nret      = ret_state;
    ndrain    = drain_next;
    nlcnt     = lcnt;
    ntmo      = tmo;
    nwinner   = WINNER;
    nbad      = 1'b0;
    handshake = 1'b0;
    case (state)
      S_IDLE: if (START) nstate = S_LDECK;
      // LOAD is a timed command: held a fixed number of cycles, not DONE-gated.
      S_LDECK, S_P1L: begin
        if (lcnt == C_LOAD_LAST) begin
          nstate = S_DRAIN;
          ndrain = (state == S_LDECK) ? S_P1W : S_C1;
        end else begin
          nlcnt = lcnt + 1'b1;
        end
      end
      S_P1W: begin
        if (P1_PLAY) begin
          nstate = S_P1L;
        end else if (P1_PASS || autopass) begin
          nstate = S_RST;
          nret   = S_P2C;
        end
      end
      S_C1: begin
        handshake = 1'b1;
        if (DONE) begin
          nstate = S_DRAIN;
          if (is_larger) begin
            ndrain = S_U1;
          end else begin
            ndrain = S_P1W;
            nbad   = 1'b1;
          end
        end
      end
      S_U1: begin
        handshake = 1'b1;
        if (DONE) begin
          if (P1_OUT_NUM == 3'd0) begin
            nstate  = S_WIN;
            nwinner = 2'b01;
          end else begin
            nstate = S_DRAIN;
            ndrain = S_P2C;
          end
        end
      end
      S_P2C: begin
        handshake = 1'b1;
        if (DONE) begin
          nstate = S_DRAIN;
          if (P2_PUT_CARD) begin
            ndrain = S_U2;
          end else begin
            ndrain = S_RST;
            nret   = S_P1W;
          end
        end
      end
      S_U2: begin
        handshake = 1'b1;
        if (DONE) begin
          if (P2_OUT_NUM == 3'd0) begin
            nstate  = S_WIN;
            nwinner = 2'b10;
          end else begin
            nstate = S_DRAIN;
            ndrain = S_P1W;
          end
        end
      end
      S_RST: begin
        handshake = 1'b1;
        if (DONE) begin
          nstate = S_DRAIN;
          ndrain = ret_state;
        end
      end
      S_DRAIN: begin
        handshake = 1'b1;
        if (!DONE) nstate = drain_next;
      end
      S_WIN, S_ERR: begin
        if (START) begin
          nstate  = S_LDECK;
          nwinner = 2'b00;
        end
      end
      default: nstate = S_IDLE;
    endcase

    // A stalled handshake (command waiting on DONE, or drain waiting on !DONE).
    if (handshake && (nstate == state)) begin
      if (tmo == C_TMO_LAST) nstate = S_ERR;
      else                   ntmo   = tmo + 1'b1;
    end

    if (nstate != state) begin
      nlcnt = '0;
      if (nstate inside {S_LDECK, S_P1L, S_C1, S_U1, S_P2C, S_U2, S_RST}) ntmo = '0;
    end
  end

  always_ff @(posedge clka or negedge RESTART_N) begin
    if (!RESTART_N) begin
      state      <= S_IDLE;
      ret_state  <= S_P1W;
      drain_next <= S_P1W;
      lcnt       <= '0;
      tmo        <= '0;
      WINNER     <= 2'b00;
      BAD_PLAY   <= 1'b0;
      LOAD       <= 1'b0;
      COMPARE_1  <= 1'b0;
      COMPARE_2  <= 1'b0;
      UPDATE_1   <= 1'b0;
      UPDATE_2   <= 1'b0;
      RESET_TOP  <= 1'b0;
      P1_TURN    <= 1'b0;
      ERR_FLAG   <= 1'b0;
      STATE      <= 4'd0;
    end else begin
      state      <= nstate;
      ret_state  <= nret;
      drain_next <= ndrain;
      lcnt       <= nlcnt;
      tmo        <= ntmo;
      WINNER     <= nwinner;
      BAD_PLAY   <= nbad;
      LOAD       <= (nstate == S_LDECK) || (nstate == S_P1L);
      COMPARE_1  <= (nstate == S_C1);
      COMPARE_2  <= (nstate == S_P2C);
      UPDATE_1   <= (nstate == S_U1);
      UPDATE_2   <= (nstate == S_U2);
      RESET_TOP  <= (nstate == S_RST);
      P1_TURN    <= (nstate == S_P1W);
      ERR_FLAG   <= (nstate == S_ERR);
      STATE      <= nstate;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_big2_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_big2_game_ctrl
// Brief   : Self-checking bench for big2_game_ctrl with a DONE-responder stub
//           and an event-order scoreboard.
// Revision: 1.0
// ============================================================================
module tb_big2_game_ctrl;

  localparam int E_LOAD = 1, E_C1 = 2, E_C2 = 3, E_U1 = 4, E_U2 = 5, E_RST = 6;
  localparam int E_TURN = 7, E_BAD = 8, E_WIN1 = 9, E_WIN2 = 10, E_ERR = 11;

  logic       clka = 1'b0, RESTART_N = 1'b1, START = 1'b0, P1_PLAY = 1'b0, P1_PASS = 1'b0;
  logic       DONE = 1'b0, is_larger = 1'b0, P2_PUT_CARD = 1'b0;
  logic [2:0] P1_OUT_NUM = 3'd3, P2_OUT_NUM = 3'd3;
  logic       LOAD, COMPARE_1, COMPARE_2, UPDATE_1, UPDATE_2, RESET_TOP;
  logic [1:0] WINNER;
  logic       P1_TURN, BAD_PLAY, ERR_FLAG;
  logic [3:0] STATE;

  int checks = 0, errors = 0;
  int sb_q[$];
  bit mute_c2 = 1'b0;
  int age = 0;
  int bad_cycles = 0;
  logic        any_cmd;
  logic [10:0] cur_ev, prev_ev = '0;

  typedef struct packed {
    logic       play, pass, larger, p2put;
    logic [2:0] p1n, p2n;
    logic [3:0] e0, e1, e2, e3, e4, e5;
    logic [3:0] exp_state;
    logic [1:0] exp_winner;
    logic [1:0] exp_bad;
  } vec_t;

  vec_t tbl[7];

  always #5 clka = ~clka;

  big2_game_ctrl #(.LOAD_CYCLES(2), .DONE_TIMEOUT(16), .P1_IDLE_LIMIT(255)) dut (
    .clka(clka), .RESTART_N(RESTART_N), .START(START), .P1_PLAY(P1_PLAY), .P1_PASS(P1_PASS),
    .DONE(DONE), .is_larger(is_larger), .P2_PUT_CARD(P2_PUT_CARD),
    .P1_OUT_NUM(P1_OUT_NUM), .P2_OUT_NUM(P2_OUT_NUM),
    .LOAD(LOAD), .COMPARE_1(COMPARE_1), .COMPARE_2(COMPARE_2), .UPDATE_1(UPDATE_1),
    .UPDATE_2(UPDATE_2), .RESET_TOP(RESET_TOP), .WINNER(WINNER), .P1_TURN(P1_TURN),
    .BAD_PLAY(BAD_PLAY), .ERR_FLAG(ERR_FLAG), .STATE(STATE)
  );

  // Datapath stub: raises DONE on the second sampled cycle of any command.
  always @(negedge clka) begin
    any_cmd = LOAD | COMPARE_1 | COMPARE_2 | UPDATE_1 | UPDATE_2 | RESET_TOP;
    if (!any_cmd) begin
      age  = 0;
      DONE = 1'b0;
    end else begin
      age++;
      DONE = (age >= 2) && !(mute_c2 && COMPARE_2);
    end
  end

  task automatic sb_pop(input int code);
    int expv;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL event: got unexpected event %0d, expected none", code);
    end else begin
      expv = sb_q.pop_front();
      if (expv != code) begin
        errors++;
        $display("FAIL event: got %0d, expected %0d", code, expv);
      end
    end
  endtask

  // Output monitor: every rising output flag is an event checked against the queue.
  always @(negedge clka) begin
    cur_ev = {ERR_FLAG, WINNER == 2'b10, WINNER == 2'b01, BAD_PLAY, P1_TURN, RESET_TOP,
              UPDATE_2, UPDATE_1, COMPARE_2, COMPARE_1, LOAD};
    if (BAD_PLAY) bad_cycles++;
    for (int i = 0; i < 11; i++)
      if (cur_ev[i] && !prev_ev[i]) sb_pop(i + 1);
    prev_ev = cur_ev;
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input int a, input int b = 0, input int c = 0, input int d = 0,
                      input int e = 0, input int f = 0);
    int ev[6];
    ev = '{a, b, c, d, e, f};
    for (int i = 0; i < 6; i++) if (ev[i] != 0) sb_q.push_back(ev[i]);
  endtask

  task automatic wait_sb(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clka);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d events pending, expected 0", tag, sb_q.size());
      sb_q.delete();
    end
    @(negedge clka);
  endtask

  task automatic pulse(input int which);
    @(negedge clka);
    case (which)
      0: START = 1'b1;
      1: P1_PLAY = 1'b1;
      2: P1_PASS = 1'b1;
      default: begin P1_PLAY = 1'b1; P1_PASS = 1'b1; end
    endcase
    @(negedge clka);
    START = 1'b0; P1_PLAY = 1'b0; P1_PASS = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clka);
    RESTART_N = 1'b0;
    repeat (3) @(negedge clka);
    RESTART_N = 1'b1;
    @(negedge clka);
  endtask

  function automatic vec_t mk(input logic play, pass, larger, p2put, input logic [2:0] p1n, p2n,
                              input int e0, e1, e2, e3, e4, e5,
                              input int st, win, bad);
    vec_t v;
    v = '{play, pass, larger, p2put, p1n, p2n, 4'(e0), 4'(e1), 4'(e2), 4'(e3), 4'(e4), 4'(e5),
          4'(st), 2'(win), 2'(bad)};
    return v;
  endfunction

  initial begin
    int n;
    tbl[0] = mk(1, 0, 0, 0, 3'd3, 3'd3, E_LOAD, E_C1, E_BAD, E_TURN, 0, 0, 2, 0, 1);
    tbl[1] = mk(1, 1, 0, 0, 3'd3, 3'd3, E_LOAD, E_C1, E_BAD, E_TURN, 0, 0, 2, 0, 1);
    tbl[2] = mk(1, 0, 1, 1, 3'd1, 3'd4, E_LOAD, E_C1, E_U1, E_C2, E_U2, E_TURN, 2, 0, 0);
    tbl[3] = mk(1, 0, 1, 0, 3'd2, 3'd4, E_LOAD, E_C1, E_U1, E_C2, E_RST, E_TURN, 2, 0, 0);
    tbl[4] = mk(0, 1, 0, 1, 3'd2, 3'd3, E_RST, E_C2, E_U2, E_TURN, 0, 0, 2, 0, 0);
    tbl[5] = mk(0, 1, 0, 0, 3'd2, 3'd3, E_RST, E_C2, E_RST, E_TURN, 0, 0, 2, 0, 0);
    tbl[6] = mk(0, 1, 0, 1, 3'd2, 3'd0, E_RST, E_C2, E_U2, E_WIN2, 0, 0, 10, 2, 0);

    // Reset state
    @(negedge clka);
    RESTART_N = 1'b0;
    #1;
    chk("reset_cmds", {LOAD, COMPARE_1, COMPARE_2, UPDATE_1, UPDATE_2, RESET_TOP}, 0);
    chk("reset_flags", {WINNER, P1_TURN, BAD_PLAY, ERR_FLAG}, 0);
    chk("reset_state", STATE, 0);
    repeat (2) @(negedge clka);
    RESTART_N = 1'b1;
    repeat (3) @(negedge clka);
    chk("idle_no_start", STATE, 0);
    pulse(2);
    repeat (4) @(negedge clka);
    chk("idle_pass_ignored", STATE, 0);

    // Game start: card counts of zero right after LOAD are not a win
    P1_OUT_NUM = 3'd0; P2_OUT_NUM = 3'd0;
    push(E_LOAD, E_TURN);
    pulse(0);
    n = 0;
    for (int i = 0; i < 40 && !P1_TURN; i++) begin
      if (LOAD) n++;
      @(negedge clka);
    end
    chk("start_load_cycles", n, 2);
    chk("start_p1_turn", P1_TURN, 1);
    chk("start_state", STATE, 2);
    chk("start_no_winner", WINNER, 0);
    wait_sb("start_events");

    pulse(0);
    repeat (6) @(negedge clka);
    chk("p1w_start_ignored", STATE, 2);

    for (int r = 0; r < 7; r++) begin
      is_larger = tbl[r].larger; P2_PUT_CARD = tbl[r].p2put;
      P1_OUT_NUM = tbl[r].p1n;   P2_OUT_NUM  = tbl[r].p2n;
      push(tbl[r].e0, tbl[r].e1, tbl[r].e2, tbl[r].e3, tbl[r].e4, tbl[r].e5);
      bad_cycles = 0;
      pulse({30'd0, tbl[r].pass, tbl[r].play} == 32'd3 ? 3 : (tbl[r].play ? 1 : 2));
      wait_sb($sformatf("row%0d_events", r));
      repeat (2) @(negedge clka);
      chk($sformatf("row%0d_state", r), STATE, int'(tbl[r].exp_state));
      chk($sformatf("row%0d_winner", r), WINNER, int'(tbl[r].exp_winner));
      chk($sformatf("row%0d_bad_cycles", r), bad_cycles, int'(tbl[r].exp_bad));
    end

    // P2 has won: WINNER holds, P1 input ignored, START clears it
    pulse(1);
    repeat (10) @(negedge clka);
    chk("win2_held", WINNER, 2);
    chk("win2_state", STATE, 10);
    P2_OUT_NUM = 3'd3;
    push(E_LOAD, E_TURN);
    pulse(0);
    chk("win2_cleared", WINNER, 0);
    wait_sb("restart_events");

    // P1 wins at UPDATE_1
    is_larger = 1'b1; P1_OUT_NUM = 3'd0;
    push(E_LOAD, E_C1, E_U1, E_WIN1);
    pulse(1);
    wait_sb("win1_events");
    chk("win1_update1_dropped", UPDATE_1, 0);
    repeat (20) @(negedge clka);
    chk("win1_held", WINNER, 1);
    chk("win1_state", STATE, 10);

    // Reset mid-COMPARE_1
    P1_OUT_NUM = 3'd3;
    push(E_LOAD, E_TURN);
    pulse(0);
    wait_sb("game3_events");
    push(E_LOAD, E_C1);
    pulse(1);
    for (int i = 0; i < 40 && !COMPARE_1; i++) @(negedge clka);
    chk("midc1_reached", COMPARE_1, 1);
    RESTART_N = 1'b0;
    #1;
    chk("midc1_cmds", {LOAD, COMPARE_1, COMPARE_2, UPDATE_1, UPDATE_2, RESET_TOP}, 0);
    chk("midc1_state", STATE, 0);
    chk("midc1_winner", WINNER, 0);
    wait_sb("midc1_events");
    RESTART_N = 1'b1;
    repeat (5) @(negedge clka);
    chk("midc1_needs_start", STATE, 0);

    // DONE never returned after COMPARE_2
    push(E_LOAD, E_TURN);
    pulse(0);
    wait_sb("game4_events");
    mute_c2 = 1'b1;
    push(E_RST, E_C2, E_ERR);
    pulse(2);
    n = 0;
    for (int i = 0; i < 100 && !ERR_FLAG; i++) begin
      if (COMPARE_2) n++;
      @(negedge clka);
    end
    chk("tmo_c2_cycles", n, 16);
    chk("tmo_err_flag", ERR_FLAG, 1);
    chk("tmo_state", STATE, 15);
    chk("tmo_cmds", {LOAD, COMPARE_1, COMPARE_2, UPDATE_1, UPDATE_2, RESET_TOP}, 0);
    wait_sb("tmo_events");
    repeat (5) @(negedge clka);
    chk("tmo_err_held", ERR_FLAG, 1);
    mute_c2 = 1'b0;
    do_reset();

`ifdef BIG2_P1_AUTOPASS_EN
    P2_PUT_CARD = 1'b0;
    push(E_LOAD, E_TURN, E_RST, E_C2, E_RST, E_TURN);
    pulse(0);
    n = 0;
    for (int i = 0; i < 400 && !RESET_TOP; i++) begin
      if (P1_TURN) n++;
      @(negedge clka);
    end
    chk("autopass_idle_cycles", n, 255);
    wait_sb("autopass_events");
`endif

    repeat (3) @(negedge clka);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
